// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: funct3 encodings, FSM state
// and the byte-lane mask used by stores.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic {INIT, RUN} state_t;

  // size is funct3[1:0]; off is the byte offset within the word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Word-organised RAM with per-byte write enables and a registered, write-first read port.
module dmem_lane_ram #(
  parameter int unsigned Depth = 128,
  parameter int unsigned AddrW = 7
) (
  input  logic             clk_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;
  logic [31:0] merged;

  // Merged word serves both the write and the write-first read.
  always_comb begin
    merged = mem_q[addr_i];
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (|be_i) mem_q[addr_i] <= merged;
    if (re_i)  rdata_q <= merged;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the core's load/store port: 512-byte RAM, legality checks, load extension,
// post-reset zero-fill sweep and saturating access counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              misalign,
  output logic              err_sticky,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int unsigned IdxW  = ADDR_W - 2;
  localparam int unsigned Depth = 1 << IdxW;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [1:0]        size, off;
  logic              req, misal, bad_f3, illegal, do_wr, do_rd;
  logic [IdxW-1:0]   ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_rdata, shifted, ext;

  logic              p_rd_q, p_bad_q;
  logic [2:0]        p_f3_q;
  logic [1:0]        p_off_q;
  logic              rd_valid_q, rd_valid_d, misalign_q, misalign_d, err_q, err_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [15:0]       wr_count_q, wr_count_d, rd_count_q, rd_count_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: sweep one word per cycle, leave INIT after the last word
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == IdxW'(Depth - 1)) state_d = RUN;
    end
  end

  // FSM output
  always_comb begin
    busy = (state_q == INIT);
  end

  always_comb begin
    size    = funct3[1:0];
    off     = addr[1:0];
    req     = wr | rd;
    misal   = ((size == 2'd2) && (off != 2'd0)) || ((size == 2'd1) && off[0]);
    // funct3 3/7 and 6 are never legal; stores have no unsigned forms.
    bad_f3  = (size == 2'd3) || (funct3[2] && (wr || (size == 2'd2)));
    illegal = req && (busy || (wr && rd) || bad_f3 || misal);
    do_wr   = wr && !illegal;
    do_rd   = rd && !illegal;
  end

  always_comb begin
    if (busy) begin
      ram_addr  = idx_q;
      ram_be    = 4'hF;
      ram_wdata = '0;
    end else begin
      ram_addr  = addr[ADDR_W-1:2];
      ram_be    = do_wr ? lane_mask(size, off) : 4'h0;
      case (size)
        2'd0:    ram_wdata = {4{wr_data[7:0]}};
        2'd1:    ram_wdata = {2{wr_data[15:0]}};
        default: ram_wdata = wr_data;
      endcase
    end
  end

  dmem_lane_ram #(
    .Depth (Depth),
    .AddrW (IdxW)
  ) u_ram (
    .clk_i   (clk),
    .addr_i  (ram_addr),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .re_i    (do_rd),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    shifted = ram_rdata >> {p_off_q, 3'b000};
    case (p_f3_q)
      F3_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  ext = {24'h0, shifted[7:0]};
      F3_LH:   ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    rd_valid_d = p_rd_q;
    misalign_d = p_bad_q;
    err_d      = err_q | p_bad_q;
    rd_data_d  = rd_data_q;
    if (p_rd_q) rd_data_d = p_bad_q ? 32'h0 : ext;
    wr_count_d = wr_count_q + {15'h0, do_wr && (wr_count_q != 16'hFFFF)};
    rd_count_d = rd_count_q + {15'h0, do_rd && (rd_count_q != 16'hFFFF)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_rd_q     <= 1'b0;
      p_bad_q    <= 1'b0;
      p_f3_q     <= 3'h0;
      p_off_q    <= 2'h0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      p_rd_q     <= rd;
      p_bad_q    <= illegal;
      p_f3_q     <= funct3;
      p_off_q    <= off;
      rd_valid_q <= rd_valid_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign misalign   = misalign_q;
  assign err_sticky = err_q;
  assign wr_count   = wr_count_q;
  assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at issue time and
// matched against rd_valid/misalign events; a byte-array model backs the random traffic.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0, rd = 1'b0;
  logic [8:0]  addr = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid, misalign, err_sticky, busy;
  logic [15:0] wr_count, rd_count;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          mis;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          exp_wr = 0;
  int          exp_rd = 0;
  logic [31:0] last_exp = '0;
  logic [7:0]  mem_m [512];

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .rd         (rd),
    .addr       (addr),
    .funct3     (funct3),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .misalign   (misalign),
    .err_sticky (err_sticky),
    .busy       (busy),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rd_valid || misalign) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got valid=%b mis=%b data=%h, none expected",
                 rd_valid, misalign, rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd_valid !== mon_e.rd || misalign !== mon_e.mis ||
            (mon_e.rd && rd_data !== mon_e.data)) begin
          errors++;
          $display("FAIL resp got valid=%b mis=%b data=%h expected valid=%b mis=%b data=%h",
                   rd_valid, misalign, rd_data, mon_e.rd, mon_e.mis, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input bit w, input bit r, input logic [8:0] a, input logic [2:0] f,
                       input logic [31:0] d);
    wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic push(input bit r, input logic [31:0] d, input bit m);
    exp_t e;
    e.rd = r; e.data = d; e.mis = m;
    exp_q.push_back(e);
    if (r) last_exp = d;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending responses, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 512; i++) mem_m[i] = 8'h00;
    exp_wr = 0;
    exp_rd = 0;
  endfunction

  function automatic void model_store(input logic [8:0] a, input logic [2:0] f,
                                      input logic [31:0] d);
    int ia = int'(a);
    mem_m[ia] = d[7:0];
    if (f[1:0] != 2'd0) mem_m[ia+1] = d[15:8];
    if (f[1:0] == 2'd2) begin
      mem_m[ia+2] = d[23:16];
      mem_m[ia+3] = d[31:24];
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f);
    int ia = int'(a);
    logic [15:0] h;
    h = {mem_m[ia+1], mem_m[ia]};
    case (f)
      3'd0:    return {{24{mem_m[ia][7]}}, mem_m[ia]};
      3'd4:    return {24'h0, mem_m[ia]};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return {mem_m[ia+3], mem_m[ia+2], h};
    endcase
  endfunction

  // Counts edges from reset release until busy falls.
  task automatic count_busy(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d, required 128", name, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    checks++;
    if ({busy, rd_valid, misalign, err_sticky} !== 4'b1000 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b v=%b mis=%b err=%b data=%h, required 1 0 0 0 0",
               busy, rd_valid, misalign, err_sticky, rd_data);
    end
    checks++;
    if (wr_count !== 16'h0 || rd_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_counts got wr=%h rd=%h, required 0 0", wr_count, rd_count);
    end
    count_busy("init");
    push(1, 32'h0, 0);
    drive(0, 1, 9'h1FC, 3'd2, 32'h0);
    exp_rd++;
    drain("init_lw");
  endtask

  task automatic test_subword();
    drive(1, 0, 9'h010, 3'd2, 32'h11223344); model_store(9'h010, 3'd2, 32'h11223344);
    drive(1, 0, 9'h011, 3'd0, 32'h000000AA); model_store(9'h011, 3'd0, 32'h000000AA);
    drive(1, 0, 9'h012, 3'd1, 32'h0000BEEF); model_store(9'h012, 3'd1, 32'h0000BEEF);
    exp_wr += 3;
    push(1, 32'hBEEFAA44, 0);
    drive(0, 1, 9'h010, 3'd2, 32'h0);
    exp_rd++;
    drain("subword");
    checks++;
    if (wr_count !== 16'(exp_wr)) begin
      errors++;
      $display("FAIL subword_wr_count got %0d, required %0d", wr_count, exp_wr);
    end
  endtask

  task automatic test_extend();
    push(1, 32'hFFFFFFAA, 0); drive(0, 1, 9'h011, 3'd0, 32'h0);
    push(1, 32'h000000AA, 0); drive(0, 1, 9'h011, 3'd4, 32'h0);
    push(1, 32'hFFFFBEEF, 0); drive(0, 1, 9'h012, 3'd1, 32'h0);
    push(1, 32'h0000BEEF, 0); drive(0, 1, 9'h012, 3'd5, 32'h0);
    exp_rd += 4;
    drain("extend");
  endtask

  task automatic test_misalign();
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_before_misalign got %b, required 0", err_sticky);
    end
    push(1, 32'h0, 1);
    drive(0, 1, 9'h002, 3'd2, 32'h0);
    drain("lw_misalign");
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL err_after_misalign got %b, required 1", err_sticky);
    end
    push(0, 32'h0, 1);
    drive(1, 0, 9'h013, 3'd1, 32'h00001234);
    push(1, 32'hBEEFAA44, 0);
    drive(0, 1, 9'h010, 3'd2, 32'h0);
    exp_rd++;
    drain("sh_misalign");
    checks++;
    if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
      errors++;
      $display("FAIL misalign_counts got wr=%0d rd=%0d, required wr=%0d rd=%0d",
               wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  task automatic test_illegal();
    push(1, 32'h0, 1);
    drive(1, 1, 9'h020, 3'd2, 32'h55555555);
    push(1, 32'h0, 0);
    drive(0, 1, 9'h020, 3'd2, 32'h0);
    push(1, 32'h0, 1);
    drive(0, 1, 9'h024, 3'd3, 32'h0);
    push(1, 32'h0, 1);
    drive(0, 1, 9'h024, 3'd6, 32'h0);
    exp_rd++;
    drain("illegal");
    checks++;
    if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
      errors++;
      $display("FAIL illegal_counts got wr=%0d rd=%0d, required wr=%0d rd=%0d",
               wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [8:0] a;
    logic [2:0] f;
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      a = 9'(9'h100 + $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        f = 3'($urandom_range(0, 2));
        if (f == 3'd2) a[1:0] = 2'b00;
        if (f == 3'd1) a[0] = 1'b0;
        d = $urandom;
        model_store(a, f, d);
        exp_wr++;
        drive(1, 0, a, f, d);
      end else begin
        f = lf[$urandom_range(0, 4)];
        if (f[1:0] == 2'd2) a[1:0] = 2'b00;
        if (f[1:0] == 2'd1) a[0] = 1'b0;
        push(1, model_load(a, f), 0);
        exp_rd++;
        drive(0, 1, a, f, 32'h0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = 9'h100 + 9'(4 * i);
      push(1, model_load(a, 3'd2), 0);
      exp_rd++;
      drive(0, 1, a, 3'd2, 32'h0);
    end
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_throughput got %0d pending, required 0", exp_q.size());
    end
    drain("b2b");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rd_data !== last_exp || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_data_hold got %h valid=%b, required %h valid=0",
               rd_data, rd_valid, last_exp);
    end
    checks++;
    if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
      errors++;
      $display("FAIL b2b_counts got wr=%0d rd=%0d, required wr=%0d rd=%0d",
               wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  task automatic test_init_request();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    push(1, 32'h0, 1);
    drive(0, 1, 9'h000, 3'd2, 32'h0);
    drain("init_req");
    checks++;
    if (err_sticky !== 1'b1 || rd_count !== 16'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL init_request got err=%b rd=%0d busy=%b, required err=1 rd=0 busy=1",
               err_sticky, rd_count, busy);
    end
    for (int i = 0; i < 200 && busy === 1'b1; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 9'h040, 3'd2, 32'hDEADBEEF);
    exp_wr++;
    drain("mid_store");
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    checks++;
    if (wr_count !== 16'h0 || rd_count !== 16'h0 || err_sticky !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got wr=%0d rd=%0d err=%b busy=%b, required 0 0 0 1",
               wr_count, rd_count, err_sticky, busy);
    end
    count_busy("mid");
    push(1, 32'h0, 0);
    drive(0, 1, 9'h040, 3'd2, 32'h0);
    drain("mid_lw");
  endtask

  initial begin
    test_reset();
    test_subword();
    test_extend();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_init_request();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
